// File: rtl/vga_source_sel_pkg.sv
// Shared definitions for the VGA source selector: bus layout, FSM codes.
// Bus (38b): vcount[37:27] vsync[26] vblnk[25] hcount[24:14] hsync[13] hblnk[12] rgb[11:0].
package vga_source_sel_pkg;

  localparam int VGA_BUS_SIZE = 38;
  localparam int VGA_RGB_W    = 12;
  localparam int VGA_HBLNK    = 12;
  localparam int VGA_VBLNK    = 25;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PENDING = 2'd1;
  localparam logic [1:0] ST_BLANK   = 2'd2;

  typedef logic [VGA_BUS_SIZE-1:0] vga_bus_t;

  // Zero the colour field during blanking or when forced dark;
  // sync and count fields pass through untouched.
  function automatic vga_bus_t vga_gate_rgb(
    input vga_bus_t bus,
    input logic     force_dark
  );
    vga_bus_t r;
    r = bus;
    if (force_dark || bus[VGA_HBLNK] || bus[VGA_VBLNK])
      r[VGA_RGB_W-1:0] = '0;
    return r;
  endfunction

endpackage

// File: rtl/vga_source_sel_frame_edge.sv
// Frame boundary detector: registers vblnk and flags its rising edge.
// Reusable by any block that needs a per-frame strobe.
module vga_frame_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic vblnk_i,
  output logic edge_o
);

  logic vblnk_q;

  // Remember last cycle's vblnk so a 0->1 transition can be seen.
  always_ff @(posedge clk_i) begin
    if (rst_i) vblnk_q <= 1'b0;
    else       vblnk_q <= vblnk_i;
  end

  assign edge_o = vblnk_i & ~vblnk_q;

endmodule

// File: rtl/vga_source_sel.sv
// Frame-synchronous N-way VGA bus selector with a registered output.
// Optional macro VGA_SEL_BLANK_EN: darken RGB for one frame after a switch.
module vga_source_sel
  import vga_source_sel_pkg::*;
#(
  parameter int N_SRC       = 2,
  parameter int SEL_W       = 3,
  parameter int DEFAULT_SRC = 0
) (
  input  logic                          pclk,
  input  logic                          rst,
  input  logic [N_SRC*VGA_BUS_SIZE-1:0] vga_in,
  input  logic [SEL_W-1:0]              sel_req,
  input  logic                          sel_req_valid,
  output logic [VGA_BUS_SIZE-1:0]       vga_out,
  output logic [SEL_W-1:0]              sel_active,
  output logic                          switch_pending,
  output logic                          sel_err,
  output logic                          frame_start
);

  localparam int              N_ENT   = 1 << SEL_W;
  localparam logic [SEL_W:0]  N_SRC_W = (SEL_W+1)'(N_SRC);
  localparam logic [SEL_W-1:0] DEF_SEL = SEL_W'(DEFAULT_SRC);

  // Unpack the inputs; unused select codes read as an all-zero bus.
  vga_bus_t src [N_ENT];

  for (genvar k = 0; k < N_ENT; k++) begin : g_src
    if (k < N_SRC) begin : g_in
      assign src[k] = vga_in[k*VGA_BUS_SIZE +: VGA_BUS_SIZE];
    end else begin : g_pad
      assign src[k] = '0;
    end
  end

  logic [1:0]       state_q, state_d;
  logic [SEL_W-1:0] pend_q, pend_d;
  logic [SEL_W-1:0] act_q, act_d;
  logic             swp_q, swp_d;
  logic             err_q, fs_q;
  vga_bus_t         out_q;

  vga_bus_t act_bus;
  logic     boundary;
  logic     in_range;
  logic     req_ok;
  logic     req_bad;
  logic     force_dark;

  assign act_bus  = src[act_q];
  assign in_range = ({1'b0, sel_req} < N_SRC_W);
  assign req_ok   = sel_req_valid & in_range;
  assign req_bad  = sel_req_valid & ~in_range;

  // Never reached unless the blanking state is built in.
  assign force_dark = (state_q == ST_BLANK);

  vga_frame_edge u_edge (
    .clk_i   (pclk),
    .rst_i   (rst),
    .vblnk_i (act_bus[VGA_VBLNK]),
    .edge_o  (boundary)
  );

  // Request capture and frame-aligned switch sequencing.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    act_d   = act_q;
    swp_d   = swp_q;
    case (state_q)
      ST_IDLE: begin
        if (req_ok && sel_req != act_q) begin
          pend_d  = sel_req;
          swp_d   = 1'b1;
          state_d = ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (req_ok) pend_d = sel_req;
        if (boundary) begin
          act_d = req_ok ? sel_req : pend_q;
          swp_d = 1'b0;
`ifdef VGA_SEL_BLANK_EN
          state_d = ST_BLANK;
`else
          state_d = ST_IDLE;
`endif
        end
      end
`ifdef VGA_SEL_BLANK_EN
      ST_BLANK: begin
        if (req_ok) begin
          pend_d = sel_req;
          swp_d  = (sel_req != act_q);
        end
        if (boundary)
          state_d = swp_d ? ST_PENDING : ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers and the one-cycle registered output stage.
  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pend_q  <= DEF_SEL;
      act_q   <= DEF_SEL;
      swp_q   <= 1'b0;
      err_q   <= 1'b0;
      fs_q    <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      act_q   <= act_d;
      swp_q   <= swp_d;
      err_q   <= req_bad;
      fs_q    <= boundary;
      out_q   <= vga_gate_rgb(act_bus, force_dark);
    end
  end

  assign vga_out        = out_q;
  assign sel_active     = act_q;
  assign switch_pending = swp_q;
  assign sel_err        = err_q;
  assign frame_start    = fs_q;

endmodule

// File: tb/tb_vga_source_sel.sv
// Directed bench for vga_source_sel with a per-cycle scoreboard.
// Uses a shrunken 20x10 raster so several frames fit in a short run.
module tb_vga_source_sel;
  import vga_source_sel_pkg::*;

  localparam int NS    = 3;
  localparam int SW    = 3;
  localparam int DEF   = 1;
  localparam int HTOT  = 20;
  localparam int HVIS  = 12;
  localparam int VTOT  = 10;
  localparam int VVIS  = 6;
  localparam int FRAME = HTOT * VTOT;
  localparam int BW    = 38;

  logic                  pclk = 1'b0;
  logic                  rst;
  logic [NS*BW-1:0]      vga_in;
  logic [SW-1:0]         sel_req;
  logic                  sel_req_valid;
  logic [VGA_BUS_SIZE-1:0] vga_out;
  logic [SW-1:0]         sel_active;
  logic                  switch_pending;
  logic                  sel_err;
  logic                  frame_start;

  always #5 pclk = ~pclk;

  vga_source_sel #(
    .N_SRC       (NS),
    .SEL_W       (SW),
    .DEFAULT_SRC (DEF)
  ) dut (
    .pclk           (pclk),
    .rst            (rst),
    .vga_in         (vga_in),
    .sel_req        (sel_req),
    .sel_req_valid  (sel_req_valid),
    .vga_out        (vga_out),
    .sel_active     (sel_active),
    .switch_pending (switch_pending),
    .sel_err        (sel_err),
    .frame_start    (frame_start)
  );

  int hc, vc;
  int pass_cnt = 0;
  int tot_cnt  = 0;
  logic [BW-1:0] exp_q [$];
  int m_act, m_psel;
  bit m_pend, prev_vb, watch0, seen0;

  function automatic logic [BW-1:0] bus_of(int k, int h, int v);
    logic [10:0] hh, vv;
    logic [3:0]  id;
    hh = 11'(h);
    vv = 11'(v);
    id = 4'(k + 1);
    return {vv, (v == VVIS + 1), (v >= VVIS),
            hh, (h >= HVIS + 2 && h < HVIS + 5), (h >= HVIS),
            id, hh[3:0], vv[3:0]};
  endfunction

  function automatic logic [BW-1:0] gated(logic [BW-1:0] b);
    logic [BW-1:0] r;
    r = b;
    if (b[12] || b[25]) r[11:0] = '0;
    return r;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    tot_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic drive();
    for (int k = 0; k < NS; k++)
      vga_in[k*BW +: BW] = bus_of(k, hc, vc);
  endtask

  task automatic cycle();
    logic [BW-1:0] e_out;
    bit ok, bnd, vb, e_err, e_fs;
    if (rst) begin
      e_out   = '0;
      m_act   = DEF;
      m_pend  = 1'b0;
      prev_vb = 1'b0;
      e_err   = 1'b0;
      e_fs    = 1'b0;
    end else begin
      e_out   = gated(bus_of(m_act, hc, vc));
      vb      = (vc >= VVIS);
      bnd     = vb && !prev_vb;
      prev_vb = vb;
      ok      = sel_req_valid && (int'(sel_req) < NS);
      e_err   = sel_req_valid && !ok;
      e_fs    = bnd;
      if (m_pend && bnd) begin
        m_act  = ok ? int'(sel_req) : m_psel;
        m_pend = 1'b0;
      end else if (ok) begin
        if (m_pend) m_psel = int'(sel_req);
        else if (int'(sel_req) != m_act) begin
          m_pend = 1'b1;
          m_psel = int'(sel_req);
        end
      end
    end
    exp_q.push_back(e_out);
    @(posedge pclk);
    #1;
    chk("vga_out", vga_out, exp_q.pop_front());
    chk("sel_active", sel_active, m_act);
    chk("switch_pending", switch_pending, m_pend);
    chk("sel_err", sel_err, e_err);
    chk("frame_start", frame_start, e_fs);
    if (watch0 && vga_out[11:8] == 4'h1) seen0 = 1'b1;
    sel_req_valid = 1'b0;
    if (rst) begin
      hc = 0;
      vc = 0;
    end else begin
      hc++;
      if (hc == HTOT) begin
        hc = 0;
        vc = (vc + 1) % VTOT;
      end
    end
    drive();
  endtask

  task automatic req(int v);
    sel_req       = SW'(v);
    sel_req_valid = 1'b1;
    cycle();
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic run_to(int h, int v);
    int n;
    n = 0;
    while (!(hc == h && vc == v) && n < 4*FRAME) begin
      cycle();
      n++;
    end
    if (n >= 4*FRAME) begin
      tot_cnt++;
      $error("FAIL run_to_timeout observed=%0d,%0d expected=%0d,%0d",
             hc, vc, h, v);
    end
  endtask

  initial begin
    int n;
    rst = 1'b1;
    sel_req = '0;
    sel_req_valid = 1'b0;
    hc = 0;
    vc = 0;
    m_act = DEF;
    m_psel = 0;
    m_pend = 1'b0;
    prev_vb = 1'b0;
    watch0 = 1'b0;
    seen0 = 1'b0;
    drive();
    run(3);
    chk("rst_active", sel_active, 1);
    chk("rst_out", vga_out, 0);
    chk("rst_pending", switch_pending, 0);
    rst = 1'b0;

    run_to(5, 1);
    cycle();
    chk("t1_pixel", vga_out,
        {11'd1, 1'b0, 1'b0, 11'd5, 1'b0, 1'b0, 4'h2, 4'h5, 4'h1});
    run_to(13, 1);
    cycle();
    chk("t1_hblank_rgb", vga_out[11:0], 0);

    run_to(5, 2);
    req(2);
    chk("t2_pending", switch_pending, 1);
    chk("t2_still1", sel_active, 1);
    run_to(0, VVIS);
    chk("t2_hold", sel_active, 1);
    cycle();
    chk("t2_apply", sel_active, 2);
    chk("t2_cleared", switch_pending, 0);
    chk("t2_fstart", frame_start, 1);

    run_to(3, 1);
    watch0 = 1'b1;
    seen0 = 1'b0;
    req(0);
    run(5);
    req(1);
    chk("t3_pending", switch_pending, 1);
    run_to(0, VVIS);
    cycle();
    chk("t3_last_wins", sel_active, 1);
    run_to(0, VVIS);
    watch0 = 1'b0;
    chk("t3_no_src0", seen0, 0);

    run_to(4, 2);
    req(5);
    chk("t4_err", sel_err, 1);
    chk("t4_active", sel_active, 1);
    chk("t4_pending", switch_pending, 0);
    cycle();
    chk("t4_err_pulse", sel_err, 0);
    req(3);
    chk("t4_err_nsrc", sel_err, 1);
    req(0);
    req(7);
    chk("t4_err_pend", sel_err, 1);
    chk("t4_pend_kept", switch_pending, 1);
    run_to(0, VVIS);
    cycle();
    chk("t4_apply0", sel_active, 0);

    run_to(0, VVIS);
    req(2);
    chk("t5_idle_bnd", sel_active, 0);
    chk("t5_captured", switch_pending, 1);
    chk("t5_fstart", frame_start, 1);
    n = 0;
    do begin
      cycle();
      n++;
    end while (sel_active != SW'(2) && n < 2*FRAME);
    chk("t5_latency", n, FRAME);

    run(10);
    req(2);
    chk("t6_same_noop", switch_pending, 0);

    run_to(2, 3);
    req(1);
    run_to(0, VVIS);
    req(0);
    chk("t7_bnd_req_wins", sel_active, 0);
    chk("t7_cleared", switch_pending, 0);

    run_to(6, 2);
    req(2);
    chk("t8_pending", switch_pending, 1);
    rst = 1'b1;
    run(2);
    chk("t8_rst_active", sel_active, 1);
    chk("t8_rst_pending", switch_pending, 0);
    chk("t8_rst_out", vga_out, 0);
    rst = 1'b0;
    run_to(0, VVIS);
    cycle();
    chk("t8_discarded", sel_active, 1);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
